avalon_pio_in_irq: RTL
======================

Name: avalon_pio_in_irq

Overview:
Parametrised Avalon-MM input PIO slave for Nios II systems, used for board switches and push-buttons. Each input bit passes through a synchroniser chain and an optional per-bit debouncer before reaching the data register. Per-bit edge capture, a maskable interrupt and a write-1-to-clear capture register are also provided. Sits on the system interconnect alongside other PIO slaves; drives one IRQ line to the CPU.

Parameters:
DATA_WIDTH, 10, number of input bits, legal range 1..32
SYNC_STAGES, 2, synchroniser flops per bit, legal range 2..4
DEBOUNCE_CYCLES, 0, consecutive stable cycles required before the debounced value changes; 0 bypasses the debouncer
EDGE_TYPE, 0, edge that sets capture: 0 rising, 1 falling, 2 any
IRQ_MODE, 1, 0 = level (irq from debounced data), 1 = edge (irq from edge capture)

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous, active-low
address  in  2  word address of register
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  registered read data, zero-extended above DATA_WIDTH
in_port  in  DATA_WIDTH  asynchronous external inputs
irq  out  1  interrupt request, active-high

Behaviour:
- Reset (asynchronous, active-low): all sync flops, debounced register, delayed copy, debounce counters, irq_mask, edge_capture and readdata are cleared to 0. irq is therefore 0.
- Register map (word addresses):
  - 0 data: read-only, debounced value.
  - 1 reserved: reads 0, writes ignored.
  - 2 irq_mask: read/write, bits [DATA_WIDTH-1:0] only.
  - 3 edge_capture: read; writing 1 to a bit clears that bit.
- Writes take effect when chipselect=1 and write_n=0 at the rising clk edge. writedata bits at and above DATA_WIDTH are ignored.
- Read latency is 1. readdata is updated on every clk edge from the address mux, with no chipselect gating. Unused upper bits always read 0.
- Sync: in_port passes through SYNC_STAGES flops per bit. sync_out reflects a pin value SYNC_STAGES edges after it is sampled.
- Debounce with DEBOUNCE_CYCLES=0: the debounced register loads sync_out every edge.
- Debounce with DEBOUNCE_CYCLES=N>0: one counter per bit, width clog2(N+1).
  - If sync_out bit equals the debounced bit, the counter is cleared.
  - Otherwise the counter increments. When the counter reaches N-1 while the bits still differ, the debounced bit takes the sync value and the counter is cleared.
  - Net effect: a change must persist N consecutive sync cycles to propagate. Any reversion before that resets the count.
- Edge detect: deb_d is a 1-cycle delayed copy of the debounced value.
  - Rising edge = deb & ~deb_d. Falling edge = ~deb & deb_d. Any = XOR of deb and deb_d.
  - A detected edge sets the edge_capture bit on the following edge. The bit is sticky until cleared.
- Simultaneous edge detect and write-1-to-clear on the same bit: set wins, and the bit stays 1.
- irq is combinational from flops, with no added latency:
  - IRQ_MODE=1: irq = OR(edge_capture & irq_mask).
  - IRQ_MODE=0: irq = OR(deb & irq_mask).
- Masking does not affect capture. Capture bits set while masked raise irq as soon as the mask bit is set.
- Reset asserted mid-debounce or mid-capture: all state is cleared immediately. After release, a pin held high produces a rising edge once it propagates through sync/debounce, because the debounced value restarts at 0.

Test Plan:
1. Reset with in_port=10'h3FF held: readdata=0 and irq=0 during reset. After release with DEBOUNCE_CYCLES=0, a read of address 0 returns 0x000003FF within SYNC_STAGES+2 cycles, and edge_capture reads 0x3FF.
2. Debounce, DEBOUNCE_CYCLES=4: in_port[0] high for 3 cycles then low leaves data bit0=0 with no capture. High for 6 cycles sets data bit0=1 and edge_capture=0x001.
3. IRQ edge mode: write irq_mask=0x004, pulse in_port[2] high then low with EDGE_TYPE=0 -> irq=1. Write 0x004 to address 3 -> edge_capture=0 and irq=0 the next cycle.
4. Masked capture: mask=0, pulse bit5 -> edge_capture=0x020 and irq=0. Then write mask=0x020 -> irq=1 the next cycle.
5. Set/clear collision: time a W1C write of 0x001 on the same edge that bit0's rising edge is captured -> edge_capture bit0 reads 1.
6. Width/map: DATA_WIDTH=32 with in_port=32'hA5A5_5A5A -> address 0 reads 0xA5A55A5A. Address 1 reads 0. With DATA_WIDTH=10, writing 0xFFFFFFFF to the mask reads back 0x000003FF.

Source files
------------

// File: rtl/avalon_pio_in_irq.sv
// Avalon-MM input PIO slave with a synchroniser and an optional debouncer per bit,
// per-bit edge capture (write-1-to-clear), an interrupt mask and a single IRQ line.
// The data register holds the debounced input value. Reads are registered with a
// latency of one cycle and return zeros above DATA_WIDTH.
module avalon_pio_in_irq #(
    parameter int DATA_WIDTH      = 10,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0,
    parameter int IRQ_MODE        = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic                  irq
);

    // Word addresses of the register map (address 1 is reserved and reads 0)
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    // Debounce counters only need to reach DEBOUNCE_CYCLES-1
    localparam int CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    logic [DATA_WIDTH-1:0] sync_reg [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] sync_out;
    logic [DATA_WIDTH-1:0] deb_reg;
    logic [DATA_WIDTH-1:0] deb_next;
    logic [DATA_WIDTH-1:0] deb_d_reg;
    logic [DATA_WIDTH-1:0] edge_det;
    logic [DATA_WIDTH-1:0] irq_mask_reg;
    logic [DATA_WIDTH-1:0] irq_mask_next;
    logic [DATA_WIDTH-1:0] edge_capture_reg;
    logic [DATA_WIDTH-1:0] edge_capture_next;
    logic [DATA_WIDTH-1:0] wr_data_bits;
    logic [31:0]           readdata_next;
    logic                  wr_en;
    logic                  wr_mask;
    logic                  wr_clear;
    logic                  unused_writedata;

    // Bus write decode; writedata bits at and above DATA_WIDTH are dropped
    assign wr_en            = chipselect & ~write_n;
    assign wr_mask          = wr_en && (address == ADDR_MASK);
    assign wr_clear         = wr_en && (address == ADDR_EDGE);
    assign wr_data_bits     = writedata[DATA_WIDTH-1:0];
    assign unused_writedata = ^writedata;

    // Synchroniser chain: in_port reaches sync_out SYNC_STAGES edges after sampling
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_reg[k] <= '0;
            end
        end else begin
            sync_reg[0] <= in_port;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_reg[k] <= sync_reg[k-1];
            end
        end
    end

    assign sync_out = sync_reg[SYNC_STAGES-1];

    // Per-bit debouncer: a change must persist DEBOUNCE_CYCLES samples to propagate
    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
            if (DEBOUNCE_CYCLES == 0) begin : g_bypass
                assign deb_next[gi] = sync_out[gi];
            end else begin : g_count
                logic [CNT_W-1:0] cnt_reg;
                logic [CNT_W-1:0] cnt_next;
                logic             differ;
                logic             done;

                assign differ       = sync_out[gi] ^ deb_reg[gi];
                assign done         = (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1));
                assign deb_next[gi] = (differ && done) ? sync_out[gi] : deb_reg[gi];
                assign cnt_next     = (!differ || done) ? '0 : cnt_reg + CNT_W'(1);

                // Count consecutive samples that disagree with the debounced bit
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_next;
                    end
                end
            end
        end
    endgenerate

    // Edge selection between the debounced value and its one-cycle delayed copy
    generate
        if (EDGE_TYPE == 0) begin : g_rise
            assign edge_det = deb_reg & ~deb_d_reg;
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign edge_det = ~deb_reg & deb_d_reg;
        end else begin : g_any
            assign edge_det = deb_reg ^ deb_d_reg;
        end
    endgenerate

    // Capture: write-1-to-clear, but a new edge on the same bit wins over the clear
    assign edge_capture_next = (edge_capture_reg & ~(wr_clear ? wr_data_bits : '0)) | edge_det;
    assign irq_mask_next     = wr_mask ? wr_data_bits : irq_mask_reg;

    // Read mux, sampled every edge regardless of chipselect
    always_comb begin
        readdata_next = '0;
        case (address)
            ADDR_DATA: readdata_next = 32'(deb_reg);
            ADDR_MASK: readdata_next = 32'(irq_mask_reg);
            ADDR_EDGE: readdata_next = 32'(edge_capture_reg);
            default:   readdata_next = '0;
        endcase
    end

    // Debounced data, its delayed copy, mask, capture and read data registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_reg          <= '0;
            deb_d_reg        <= '0;
            irq_mask_reg     <= '0;
            edge_capture_reg <= '0;
            readdata         <= '0;
        end else begin
            deb_reg          <= deb_next;
            deb_d_reg        <= deb_reg;
            irq_mask_reg     <= irq_mask_next;
            edge_capture_reg <= edge_capture_next;
            readdata         <= readdata_next;
        end
    end

    // Interrupt taken straight from registers so it adds no latency
    generate
        if (IRQ_MODE == 1) begin : g_irq_edge
            assign irq = |(edge_capture_reg & irq_mask_reg);
        end else begin : g_irq_level
            assign irq = |(deb_reg & irq_mask_reg);
        end
    endgenerate

endmodule
